// File: rtl/draw_cmd_sequencer.sv
// Line-primitive sequencer: walks a start/length/direction command pixel by
// pixel and issues RGB444 framebuffer writes on the 800-pixel-pitch VGA map.
module draw_cmd_sequencer #(
  parameter int unsigned H_MIN      = 144,
  parameter int unsigned H_MAX      = 783,
  parameter int unsigned V_MIN      = 35,
  parameter int unsigned V_MAX      = 514,
  parameter int unsigned LINE_PITCH = 800,
  parameter int unsigned LEN_W      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_type,
  input  logic [15:0]      cmd_x0,
  input  logic [15:0]      cmd_y0,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [2:0]       cmd_color,
  output logic             fb_we,
  output logic [18:0]      fb_addr,
  output logic [11:0]      fb_data,
  input  logic             fb_ack,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAW,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_cx;
  logic [15:0]      r_cy;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [1:0]       r_type;
  logic [11:0]      r_color;
  logic [18:0]      r_addr;

  logic        w_accept;
  logic        w_in_win;
  logic        w_adv;
  logic        w_last;
  logic [15:0] w_nx;
  logic [15:0] w_ny;

  function automatic logic [11:0] decode_color(input logic [2:0] c);
    case (c)
      3'd1:    return 12'hF00;
      3'd2:    return 12'h0F0;
      3'd3:    return 12'h00F;
      3'd4:    return 12'hFFF;
      default: return 12'h000;
    endcase
  endfunction

  // Full-width product, then keep the low 19 bits of the RAM address.
  function automatic logic [18:0] pix_addr(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] full;
    full = 32'(y) * 32'(LINE_PITCH) + 32'(x);
    return full[18:0];
  endfunction

  assign w_accept = (r_state == S_IDLE) && cmd_valid;

  // A coordinate that wrapped through 0/65535 lands outside these bounds, so it is clipped.
  assign w_in_win = (r_cx >= 16'(H_MIN)) && (r_cx <= 16'(H_MAX)) &&
                    (r_cy >= 16'(V_MIN)) && (r_cy <= 16'(V_MAX));

  // Clipped pixels retire after one cycle; visible ones wait for the RAM port.
  assign w_adv  = (r_state == S_DRAW) && (!w_in_win || fb_ack);
  assign w_last = ({1'b0, r_cnt} + 1'b1) == {1'b0, r_len};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_nx = r_cx + 16'd1;
    w_ny = r_cy;
    case (r_type)
      2'd1: begin
        w_nx = r_cx;
        w_ny = r_cy + 16'd1;
      end
      2'd2: begin
        w_nx = r_cx - 16'd1;
        w_ny = r_cy + 16'd1;
      end
      2'd3: begin
        w_nx = r_cx + 16'd1;
        w_ny = r_cy + 16'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (cmd_valid) w_state_nxt = (cmd_len != '0) ? S_DRAW : S_DONE;
      S_DRAW: if (w_adv && w_last) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    // NOTE: all datapath registers are cleared by reset; there is no storage array here that would need to be left unreset.
    if (rst) begin
      r_cx    <= '0;
      r_cy    <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_type  <= '0;
      r_color <= '0;
      r_addr  <= '0;
    end else if (w_accept) begin
      r_cx    <= cmd_x0;
      r_cy    <= cmd_y0;
      r_len   <= cmd_len;
      r_cnt   <= '0;
      r_type  <= cmd_type;
      r_color <= decode_color(cmd_color);
      if (cmd_len != '0) r_addr <= pix_addr(cmd_x0, cmd_y0);
    end else if (w_adv) begin
      r_cx  <= w_nx;
      r_cy  <= w_ny;
      r_cnt <= r_cnt + 1'b1;
      // The final advance leaves the address of the last pixel on the bus.
      if (!w_last) r_addr <= pix_addr(w_nx, w_ny);
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign fb_we     = (r_state == S_DRAW) && w_in_win;
  assign fb_addr   = r_addr;
  assign fb_data   = r_color;

endmodule

// File: tb/tb_draw_cmd_sequencer.sv
// Self-checking bench for draw_cmd_sequencer: directed cases plus random lines
// compared pixel by pixel against a coordinate/arithmetic reference model.
module tb_draw_cmd_sequencer;

  localparam int LEN_W = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_type;
  logic [15:0]      cmd_x0;
  logic [15:0]      cmd_y0;
  logic [LEN_W-1:0] cmd_len;
  logic [2:0]       cmd_color;
  logic             fb_we;
  logic [18:0]      fb_addr;
  logic [11:0]      fb_data;
  logic             fb_ack;
  logic             busy;
  logic             done;

  int n_vec = 0;
  int n_err = 0;

  draw_cmd_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_len   (cmd_len),
    .cmd_color (cmd_color),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .fb_ack    (fb_ack),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Position of pixel i along the line, in 16-bit wrap-around coordinates.
  function automatic logic [15:0] model_x(input logic [15:0] x0, input logic [1:0] t, input int i);
    case (t)
      2'd1:    return x0;
      2'd2:    return x0 - 16'(i);
      default: return x0 + 16'(i);
    endcase
  endfunction

  function automatic logic [15:0] model_y(input logic [15:0] y0, input logic [1:0] t, input int i);
    return (t == 2'd0) ? y0 : y0 + 16'(i);
  endfunction

  function automatic bit visible(input logic [15:0] x, input logic [15:0] y);
    return (int'(x) >= 144) && (int'(x) <= 783) && (int'(y) >= 35) && (int'(y) <= 514);
  endfunction

  function automatic logic [31:0] addr_of(input logic [15:0] x, input logic [15:0] y);
    int unsigned a;
    a = int'(y) * 800 + int'(x);
    return a % (1 << 19);
  endfunction

  function automatic logic [11:0] rgb(input logic [2:0] c);
    case (c)
      3'd1:    return 12'hF00;
      3'd2:    return 12'h0F0;
      3'd3:    return 12'h00F;
      3'd4:    return 12'hFFF;
      default: return 12'h000;
    endcase
  endfunction

  // ack_mode: 0 always ack, 1 random ack, 2 hold ack low for 3 visible cycles first.
  // pester: keep offering a different command while the line is being drawn.
  task automatic run_cmd(input logic [1:0] t, input logic [15:0] x0, input logic [15:0] y0,
                         input int len, input logic [2:0] c, input int ack_mode, input bit pester);
    int          i;
    int          cyc;
    int          stall;
    bit          win;
    bit          ack;
    logic [15:0] x;
    logic [15:0] y;
    @(negedge clk);
    check("ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_x0    = x0;
    cmd_y0    = y0;
    cmd_len   = LEN_W'(len);
    cmd_color = c;
    fb_ack    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (pester) begin
      cmd_valid = 1'b1;
      cmd_type  = 2'($urandom);
      cmd_x0    = 16'($urandom_range(144, 783));
      cmd_y0    = 16'($urandom_range(35, 514));
      cmd_len   = LEN_W'(7);
      cmd_color = 3'($urandom);
    end else begin
      cmd_valid = 1'b0;
    end
    i     = 0;
    cyc   = 0;
    stall = (ack_mode == 2) ? 3 : 0;
    while (i < len && cyc < 4 * len + 40) begin
      x   = model_x(x0, t, i);
      y   = model_y(y0, t, i);
      win = visible(x, y);
      check("busy_draw", busy, 1);
      check("ready_draw", cmd_ready, 0);
      check("done_draw", done, 0);
      check("we_draw", fb_we, 32'(win));
      if (win) begin
        check("addr", fb_addr, addr_of(x, y));
        check("data", fb_data, 32'(rgb(c)));
      end
      case (ack_mode)
        0:       ack = 1'b1;
        1:       ack = ($urandom_range(0, 2) != 0);
        default: begin
          if (stall > 0 && win) begin
            ack = 1'b0;
            stall--;
          end else begin
            ack = 1'b1;
          end
        end
      endcase
      fb_ack = ack;
      @(posedge clk);
      if (!win || ack) i++;
      cyc++;
      @(negedge clk);
    end
    if (i < len) check("draw_timeout", 32'(i), 32'(len));
    check("done_pulse", done, 1);
    check("busy_done", busy, 1);
    check("ready_done", cmd_ready, 0);
    check("we_done", fb_we, 0);
    cmd_valid = 1'b0;
    fb_ack    = 1'($urandom);
    @(posedge clk);
    @(negedge clk);
    check("done_clear", done, 0);
    check("busy_idle", busy, 0);
    check("ready_after", cmd_ready, 1);
    check("we_idle", fb_we, 0);
  endtask

  initial begin
    logic [15:0] rx;
    logic [15:0] ry;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_type  = '0;
    cmd_x0    = '0;
    cmd_y0    = '0;
    cmd_len   = '0;
    cmd_color = '0;
    fb_ack    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_we", fb_we, 0);
    check("rst_addr", fb_addr, 0);
    check("rst_data", fb_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    // Directed cases from the line-drawing scenarios.
    run_cmd(2'd0, 16'd144, 16'd35,  3, 3'd1, 0, 1'b0);
    run_cmd(2'd2, 16'd783, 16'd35,  2, 3'd2, 0, 1'b0);
    run_cmd(2'd1, 16'd200, 16'd513, 4, 3'd4, 0, 1'b0);
    run_cmd(2'd3, 16'd300, 16'd100, 2, 3'd3, 2, 1'b0);
    run_cmd(2'd0, 16'd400, 16'd200, 0, 3'd6, 0, 1'b1);
    run_cmd(2'd1, 16'd400, 16'd200, 5, 3'd1, 1, 1'b1);
    run_cmd(2'd2, 16'd0,   16'd35,  3, 3'd4, 0, 1'b0);

    // Reset in the middle of a visible line.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_type  = 2'd0;
    cmd_x0    = 16'd200;
    cmd_y0    = 16'd100;
    cmd_len   = LEN_W'(10);
    cmd_color = 3'd3;
    fb_ack    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_we0", fb_we, 1);
    check("mid_addr0", fb_addr, addr_of(16'd200, 16'd100));
    @(posedge clk);
    @(negedge clk);
    check("mid_addr1", fb_addr, addr_of(16'd201, 16'd100));
    @(posedge clk);
    @(negedge clk);
    check("mid_we2", fb_we, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_we", fb_we, 0);
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_done", done, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_addr", fb_addr, 0);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("mid_no_done", done, 0);
      check("mid_no_we", fb_we, 0);
    end
    run_cmd(2'd3, 16'd150, 16'd40, 4, 3'd2, 0, 1'b0);

    // Randomized lines, including far-off and wrapping start points.
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 3))
        0:       begin rx = 16'($urandom); ry = 16'($urandom); end
        1:       begin rx = 16'($urandom_range(0, 3)); ry = 16'($urandom_range(30, 520)); end
        default: begin rx = 16'($urandom_range(120, 800)); ry = 16'($urandom_range(20, 530)); end
      endcase
      run_cmd(2'($urandom), rx, ry, int'($urandom_range(0, 24)), 3'($urandom),
              int'($urandom_range(0, 1)), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
